// File: rtl/bakery_pkg.sv
// Shared types and helpers for the bakery mutual-exclusion model.
// Optional monitor macro: BAKERY_MUTEX_MON_EN.
package bakery_pkg;

  localparam int DEF_N_PROC = 4;
  localparam int DEF_TICKET_W = 3;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CHOOSE = 3'd1,
    WAIT   = 3'd2,
    CS     = 3'd3,
    EXIT   = 3'd4
  } pc_t;

  // 1 + max, clamped to the largest ticket a tw-bit field can hold
  function automatic int unsigned ticket_max(
    input int unsigned mx,
    input int unsigned tw
  );
    int unsigned lim;
    lim = (32'd1 << tw) - 32'd1;
    return (mx >= lim) ? lim : mx + 32'd1;
  endfunction

  function automatic logic lex_lt(
    input int unsigned ta,
    input int unsigned ia,
    input int unsigned tb,
    input int unsigned ib
  );
    return (ta < tb) || ((ta == tb) && (ia < ib));
  endfunction

endpackage

// File: rtl/bakery_if.sv
// Scheduler/strategy side of the bakery model and its observed state.
// Optional monitor macro: BAKERY_MUTEX_MON_EN.
interface bakery_if #(
  parameter int N_PROC = bakery_pkg::DEF_N_PROC,
  parameter int TICKET_W = bakery_pkg::DEF_TICKET_W,
  parameter int SEL_W = $clog2(N_PROC)
);
  logic [SEL_W-1:0]           sym_break;
  logic [SEL_W-1:0]           select;
  logic                       pause;
  logic [N_PROC-1:0]          want;
  logic [3*N_PROC-1:0]        pc;
  logic [TICKET_W*N_PROC-1:0] ticket;
  logic [N_PROC-1:0]          in_cs;
  logic                       overflow;
  logic                       mutex_viol;

  modport master (
    output sym_break, select, pause, want,
    input  pc, ticket, in_cs, overflow, mutex_viol
  );

  modport slave (
    input  sym_break, select, pause, want,
    output pc, ticket, in_cs, overflow, mutex_viol
  );
endinterface

// File: rtl/bakery_proc.sv
// One bakery process: pc, ticket, choosing flag and scan index.
// Optional monitor macro: BAKERY_MUTEX_MON_EN (not used here).
module bakery_proc
  import bakery_pkg::*;
#(
  parameter int N_PROC = DEF_N_PROC,
  parameter int TICKET_W = DEF_TICKET_W,
  parameter int SEL_W = $clog2(N_PROC),
  parameter int ID = 0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       step,
  input  logic                       want,
  input  logic [TICKET_W*N_PROC-1:0] tickets,
  input  logic [N_PROC-1:0]          choosing_all,
  input  logic [SEL_W-1:0]           sym_break,
  output pc_t                        pc,
  output logic [TICKET_W-1:0]        ticket,
  output logic                       choosing,
  output logic                       ovf_hit
);
  localparam logic [SEL_W-1:0] MY_ID = SEL_W'(ID);
  localparam logic [SEL_W-1:0] LAST = SEL_W'(N_PROC - 1);
  localparam logic [TICKET_W-1:0] T_MAX = '1;

  logic [SEL_W-1:0]    scan;
  logic [TICKET_W-1:0] mx;
  logic [TICKET_W-1:0] tj;
  logic                blocked;

  always_comb begin
    mx = '0;
    for (int i = 0; i < N_PROC; i++)
      if (tickets[i*TICKET_W +: TICKET_W] > mx)
        mx = tickets[i*TICKET_W +: TICKET_W];
  end

  // a peer blocks while choosing or while holding a smaller (ticket, id)
  always_comb begin
    tj = tickets[int'(scan)*TICKET_W +: TICKET_W];
    blocked = 1'b0;
    if (scan != MY_ID)
      blocked = choosing_all[scan] ||
        ((tj != '0) &&
         lex_lt(32'(tj), 32'(scan ^ sym_break),
                32'(ticket), 32'(MY_ID ^ sym_break)));
  end

  assign ovf_hit = step && (pc == CHOOSE) && (mx == T_MAX);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc       <= IDLE;
      ticket   <= '0;
      choosing <= 1'b0;
      scan     <= '0;
    end else if (step) begin
      unique case (pc)
        IDLE: begin
          if (want) begin
            pc       <= CHOOSE;
            choosing <= 1'b1;
          end
        end
        CHOOSE: begin
          ticket   <= TICKET_W'(ticket_max(32'(mx), TICKET_W));
          choosing <= 1'b0;
          scan     <= '0;
          pc       <= WAIT;
        end
        WAIT: begin
          if (!blocked) begin
            scan <= scan + 1'b1;
            if (scan == LAST) pc <= CS;
          end
        end
        CS: pc <= EXIT;
        EXIT: begin
          ticket <= '0;
          pc     <= IDLE;
        end
        default: pc <= IDLE;
      endcase
    end
  end
endmodule

// File: rtl/bakery_system.sv
// Bakery system: select decode, pause gating, packing, overflow flag.
// Define BAKERY_MUTEX_MON_EN to build the sticky mutual-exclusion monitor.
module bakery_system
  import bakery_pkg::*;
#(
  parameter int N_PROC = DEF_N_PROC,
  parameter int TICKET_W = DEF_TICKET_W,
  parameter int SEL_W = $clog2(N_PROC)
) (
  input logic     clk,
  input logic     reset,
  bakery_if.slave bus
);
  logic [N_PROC-1:0]          step;
  logic [N_PROC-1:0]          choosing;
  logic [N_PROC-1:0]          ovf_hit;
  logic [N_PROC-1:0]          cs_vec;
  logic [TICKET_W*N_PROC-1:0] tickets;
  logic [3*N_PROC-1:0]        pcs;
  logic                       overflow_q;

  always_comb begin
    step = '0;
    if (!bus.pause) step[bus.select] = 1'b1;
  end

  for (genvar i = 0; i < N_PROC; i++) begin : g_proc
    pc_t pc_i;

    bakery_proc #(
      .N_PROC(N_PROC),
      .TICKET_W(TICKET_W),
      .SEL_W(SEL_W),
      .ID(i)
    ) u_proc (
      .clk(clk),
      .reset(reset),
      .step(step[i]),
      .want(bus.want[i]),
      .tickets(tickets),
      .choosing_all(choosing),
      .sym_break(bus.sym_break),
      .pc(pc_i),
      .ticket(tickets[i*TICKET_W +: TICKET_W]),
      .choosing(choosing[i]),
      .ovf_hit(ovf_hit[i])
    );

    assign pcs[3*i +: 3] = pc_i;
    assign cs_vec[i] = (pc_i == CS);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) overflow_q <= 1'b0;
    else if (|ovf_hit) overflow_q <= 1'b1;
  end

  assign bus.pc = pcs;
  assign bus.ticket = tickets;
  assign bus.in_cs = cs_vec;
  assign bus.overflow = overflow_q;

`ifdef BAKERY_MUTEX_MON_EN
  logic viol_q;

  // more than one bit set means two processes share the critical section
  always_ff @(posedge clk or posedge reset) begin
    if (reset) viol_q <= 1'b0;
    else if ((cs_vec & (cs_vec - 1'b1)) != '0) viol_q <= 1'b1;
  end

  assign bus.mutex_viol = viol_q;
`else
  assign bus.mutex_viol = 1'b0;
`endif
endmodule

// File: tb/tb_bakery_system.sv
// Directed bench for bakery_system: 3-bit and 2-bit ticket instances.
// Adds a random monitor run when BAKERY_MUTEX_MON_EN is defined.
module tb_bakery_system;
  logic clk = 1'b0;
  logic reset;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  bakery_if #(.N_PROC(4), .TICKET_W(3)) a ();
  bakery_if #(.N_PROC(4), .TICKET_W(2)) b ();

  bakery_system #(.N_PROC(4), .TICKET_W(3)) dut_a (
    .clk(clk), .reset(reset), .bus(a.slave));
  bakery_system #(.N_PROC(4), .TICKET_W(2)) dut_b (
    .clk(clk), .reset(reset), .bus(b.slave));

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic step_a(input int sel);
    a.select = 2'(sel);
    a.pause = 1'b0;
    @(posedge clk);
    @(negedge clk);
    a.pause = 1'b1;
  endtask

  task automatic step_b(input int sel);
    b.select = 2'(sel);
    b.pause = 1'b0;
    @(posedge clk);
    @(negedge clk);
    b.pause = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if (a.pc !== 12'h000) begin
      bad++; $display("FAIL reset_pc got=%h exp=000", a.pc);
    end
    total++;
    if (a.ticket !== 12'h000) begin
      bad++; $display("FAIL reset_ticket got=%h exp=000", a.ticket);
    end
    total++;
    if (a.in_cs !== 4'h0) begin
      bad++; $display("FAIL reset_in_cs got=%b exp=0000", a.in_cs);
    end
    total++;
    if (a.overflow !== 1'b0) begin
      bad++; $display("FAIL reset_overflow got=%b exp=0", a.overflow);
    end
    total++;
    if (a.mutex_viol !== 1'b0) begin
      bad++; $display("FAIL reset_mutex_viol got=%b exp=0", a.mutex_viol);
    end
    total++;
    if (b.pc !== 12'h000 || b.overflow !== 1'b0) begin
      bad++; $display("FAIL reset_b got pc=%h ovf=%b exp pc=000 ovf=0",
                      b.pc, b.overflow);
    end
  endtask

  task automatic test_single();
    int sp[8] = '{1, 2, 2, 2, 2, 3, 4, 0};
    int st[8] = '{0, 1, 1, 1, 1, 1, 1, 0};
    logic [11:0] ep;
    logic [11:0] et;
    a.want = 4'b0000;
    a.sym_break = 2'b00;
    step_a(0);
    total++;
    if (a.pc !== 12'h000) begin
      bad++; $display("FAIL idle_no_want got=%h exp=000", a.pc);
    end
    a.want = 4'b0100;
    for (int k = 0; k < 8; k++) begin
      step_a(2);
      ep = 12'(sp[k] << 6);
      et = 12'(st[k] << 6);
      total++;
      if (a.pc !== ep || a.ticket !== et) begin
        bad++;
        $display("FAIL single_step%0d got pc=%h t=%h exp pc=%h t=%h",
                 k, a.pc, a.ticket, ep, et);
      end
      if (k == 5) begin
        total++;
        if (a.in_cs !== 4'b0100) begin
          bad++; $display("FAIL single_in_cs got=%b exp=0100", a.in_cs);
        end
      end
    end
  endtask

  task automatic test_order();
    int os[20] = '{0, 1, 0, 0, 0, 0, 1, 0, 0, 0,
                   1, 1, 1, 1, 0, 0, 1, 1, 1, 1};
    int p0[20] = '{1, 1, 2, 2, 2, 2, 2, 2, 2, 3,
                   3, 3, 3, 3, 4, 0, 0, 0, 0, 0};
    int p1[20] = '{0, 1, 1, 1, 1, 1, 2, 2, 2, 2,
                   2, 2, 2, 2, 2, 2, 2, 2, 2, 3};
    int t0[20] = '{0, 0, 1, 1, 1, 1, 1, 1, 1, 1,
                   1, 1, 1, 1, 1, 0, 0, 0, 0, 0};
    int t1[20] = '{0, 0, 0, 0, 0, 0, 2, 2, 2, 2,
                   2, 2, 2, 2, 2, 2, 2, 2, 2, 2};
    logic [11:0] ep;
    logic [11:0] et;
    do_reset();
    a.want = 4'b0011;
    a.sym_break = 2'b00;
    for (int k = 0; k < 20; k++) begin
      step_a(os[k]);
      ep = 12'(p0[k] | (p1[k] << 3));
      et = 12'(t0[k] | (t1[k] << 3));
      total++;
      if (a.pc !== ep || a.ticket !== et) begin
        bad++;
        $display("FAIL order_step%0d got pc=%h t=%h exp pc=%h t=%h",
                 k, a.pc, a.ticket, ep, et);
      end
    end
    total++;
    if (a.in_cs !== 4'b0010) begin
      bad++; $display("FAIL order_in_cs got=%b exp=0010", a.in_cs);
    end
  endtask

  task automatic test_pause();
    a.pause = 1'b1;
    for (int k = 0; k < 5; k++) begin
      a.select = 2'(k);
      a.want = 4'($urandom);
      @(posedge clk);
      @(negedge clk);
      total++;
      if (a.pc !== 12'h018 || a.ticket !== 12'h010 ||
          a.overflow !== 1'b0) begin
        bad++;
        $display("FAIL pause_cyc%0d got pc=%h t=%h ovf=%b exp 018 010 0",
                 k, a.pc, a.ticket, a.overflow);
      end
    end
    step_a(1);
    total++;
    if (a.pc !== 12'h020) begin
      bad++; $display("FAIL pause_resume got=%h exp=020", a.pc);
    end
    step_a(1);
    total++;
    if (a.pc !== 12'h000 || a.ticket !== 12'h000) begin
      bad++; $display("FAIL pause_exit got pc=%h t=%h exp 000 000",
                      a.pc, a.ticket);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    a.want = 4'b1000;
    for (int k = 0; k < 6; k++) step_a(3);
    total++;
    if (a.pc !== 12'h600 || a.ticket !== 12'h200 ||
        a.in_cs !== 4'b1000) begin
      bad++;
      $display("FAIL async_pre got pc=%h t=%h cs=%b exp 600 200 1000",
               a.pc, a.ticket, a.in_cs);
    end
    #2 reset = 1'b1;
    #1;
    total++;
    if (a.pc !== 12'h000 || a.ticket !== 12'h000 ||
        a.in_cs !== 4'b0000) begin
      bad++;
      $display("FAIL async_reset got pc=%h t=%h cs=%b exp 000 000 0000",
               a.pc, a.ticket, a.in_cs);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic w2_setup(input logic sb);
    int ss[8] = '{0, 0, 1, 1, 2, 2, 3, 3};
    do_reset();
    b.sym_break = {1'b0, sb};
    b.want = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      step_b(ss[k]);
      if (k == 5) begin
        total++;
        if (b.ticket !== 8'h39 || b.overflow !== 1'b0) begin
          bad++; $display("FAIL w2_no_sat got t=%h ovf=%b exp 39 0",
                          b.ticket, b.overflow);
        end
      end
    end
    total++;
    if (b.ticket !== 8'hF9 || b.overflow !== 1'b1 || b.pc !== 12'h492) begin
      bad++; $display("FAIL w2_sat got t=%h ovf=%b pc=%h exp F9 1 492",
                      b.ticket, b.overflow, b.pc);
    end
    for (int k = 0; k < 4; k++) step_b(0);
    total++;
    if (b.in_cs !== 4'b0001) begin
      bad++; $display("FAIL w2_p0_cs got=%b exp=0001", b.in_cs);
    end
    step_b(0);
    step_b(0);
    for (int k = 0; k < 4; k++) step_b(1);
    total++;
    if (b.in_cs !== 4'b0010) begin
      bad++; $display("FAIL w2_p1_cs got=%b exp=0010", b.in_cs);
    end
    step_b(1);
    step_b(1);
    total++;
    if (b.pc !== 12'h480 || b.ticket !== 8'hF0 || b.overflow !== 1'b1) begin
      bad++; $display("FAIL w2_tie_ready got pc=%h t=%h ovf=%b exp 480 F0 1",
                      b.pc, b.ticket, b.overflow);
    end
  endtask

  task automatic test_tie(input logic sb, input int win, input int lose,
                          input int n);
    logic [3:0] ew;
    logic [3:0] el;
    ew = 4'(1 << win);
    el = 4'(1 << lose);
    w2_setup(sb);
    for (int k = 0; k < 4; k++) step_b(lose);
    total++;
    if (b.pc !== 12'h480 || b.in_cs !== 4'b0000) begin
      bad++; $display("FAIL tie%0d_lose_blocked got pc=%h cs=%b exp 480 0000",
                      sb, b.pc, b.in_cs);
    end
    for (int k = 0; k < 4; k++) step_b(win);
    total++;
    if (b.in_cs !== ew) begin
      bad++; $display("FAIL tie%0d_winner got=%b exp=%b", sb, b.in_cs, ew);
    end
    step_b(win);
    step_b(win);
    for (int k = 0; k < n; k++) step_b(lose);
    total++;
    if (b.in_cs !== el || b.overflow !== 1'b1) begin
      bad++; $display("FAIL tie%0d_loser got cs=%b ovf=%b exp %b 1",
                      sb, b.in_cs, b.overflow, el);
    end
  endtask

  task automatic test_overflow_clear();
    do_reset();
    total++;
    if (b.overflow !== 1'b0) begin
      bad++; $display("FAIL ovf_clear got=%b exp=0", b.overflow);
    end
  endtask

`ifdef BAKERY_MUTEX_MON_EN
  task automatic test_mutex_random();
    logic seen;
    seen = 1'b0;
    do_reset();
    for (int k = 0; k < 10000; k++) begin
      a.select = 2'($urandom_range(0, 3));
      a.want = 4'($urandom);
      a.sym_break = 2'($urandom);
      a.pause = 1'b0;
      @(posedge clk);
      @(negedge clk);
      total++;
      if (a.mutex_viol !== seen) begin
        bad++; $display("FAIL mutex_cyc%0d got=%b exp=%b",
                        k, a.mutex_viol, seen);
      end
      if ((a.in_cs & (a.in_cs - 4'd1)) != 4'd0) seen = 1'b1;
    end
    a.pause = 1'b1;
  endtask
`endif

  initial begin
    reset = 1'b1;
    a.pause = 1'b1; a.select = '0; a.want = '0; a.sym_break = '0;
    b.pause = 1'b1; b.select = '0; b.want = '0; b.sym_break = '0;
    test_reset();
    test_single();
    test_order();
    test_pause();
    test_async_reset();
    test_tie(1'b0, 2, 3, 2);
    test_tie(1'b1, 3, 2, 1);
    test_overflow_clear();
`ifdef BAKERY_MUTEX_MON_EN
    test_mutex_random();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
